// File: rtl/fejkon_pcie_rx_decode.sv
// BAR0 single-beat memory-request TLP decoder: turns MWr32/MRd32 into register requests and flags URs.
// Optional FEJKON_RX_DECODE_STATS_EN adds stat_wr/stat_rd/stat_ur event counters.
module fejkon_pcie_rx_decode #(
    parameter int BAR_ADDR_WIDTH = 12,
    parameter int MAX_PENDING    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [255:0]              rx_st_data,
    input  logic                      rx_st_valid,
    input  logic                      rx_st_sop,
    input  logic                      rx_st_eop,
    input  logic [7:0]                rx_st_bar,
    output logic                      rx_st_ready,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [BAR_ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]               wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [BAR_ADDR_WIDTH-1:0] rd_addr,
    output logic [15:0]               rd_req_id,
    output logic [7:0]                rd_tag,
    output logic                      rd_ur,
    input  logic                      cpl_done,
    output logic                      cpl_err_ur_p,
    output logic                      cpl_err_ur_np,
`ifdef FEJKON_RX_DECODE_STATS_EN
    output logic [31:0]               stat_wr,
    output logic [31:0]               stat_rd,
    output logic [31:0]               stat_ur,
`endif
    output logic [5:0]                pending
);

    typedef enum logic [1:0] {S_IDLE, S_WR_OUT, S_RD_OUT, S_DROP} state_e;

    state_e                    state_q;
    logic                      wr_valid_q, rd_valid_q, rd_ur_q, ur_p_q, ur_np_q;
    logic [BAR_ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
    logic [31:0]               wr_data_q;
    logic [15:0]               rd_req_id_q;
    logic [7:0]                rd_tag_q;
    logic [5:0]                pending_q, pending_d;

    logic [31:0] dw0, dw1, dw2, dw3, dw4, addr_w, data_w;
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [9:0]  len;
    logic        is_mem, is_wr, is_4dw, hdr_ok, beat_acc, sop_acc, rd_hs, cpl_dec;

    assign dw0    = rx_st_data[31:0];
    assign dw1    = rx_st_data[63:32];
    assign dw2    = rx_st_data[95:64];
    assign dw3    = rx_st_data[127:96];
    assign dw4    = rx_st_data[159:128];
    assign fmt    = dw0[31:29];
    assign typ    = dw0[28:24];
    assign len    = dw0[9:0];
    assign addr_w = {dw2[31:2], 2'b00};
    // Qword-aligned payload placement: DW3 is padding when the address is 8-byte aligned
    assign data_w = addr_w[2] ? dw3 : dw4;

    assign is_mem = (typ == 5'd0) && !fmt[2];
    assign is_wr  = fmt[1];
    assign is_4dw = fmt[0];
    assign hdr_ok = (len == 10'd1) && (dw1[3:0] == 4'hF) && (dw1[7:4] == 4'h0) &&
                    rx_st_bar[0] && ((addr_w >> BAR_ADDR_WIDTH) == 32'd0) &&
                    rx_st_eop && !is_4dw;

    assign rx_st_ready = ((state_q == S_IDLE) && (pending_q < 6'(MAX_PENDING))) ||
                         (state_q == S_DROP);
    assign beat_acc = rx_st_valid && rx_st_ready;
    assign sop_acc  = beat_acc && rx_st_sop && (state_q == S_IDLE);
    assign rd_hs    = rd_valid_q && rd_ready;
    assign cpl_dec  = cpl_done && (pending_q != 6'd0);

    always_comb begin
        pending_d = pending_q;
        if (rd_hs && !cpl_dec)
            pending_d = pending_q + 6'd1;
        else if (!rd_hs && cpl_dec)
            pending_d = pending_q - 6'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_valid_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_ur_q     <= 1'b0;
            ur_p_q      <= 1'b0;
            ur_np_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            rd_req_id_q <= '0;
            rd_tag_q    <= '0;
            pending_q   <= '0;
        end else begin
            ur_p_q    <= 1'b0;
            ur_np_q   <= 1'b0;
            pending_q <= pending_d;
            case (state_q)
                S_IDLE: begin
                    if (sop_acc) begin
                        if (!rx_st_eop) begin
                            state_q <= S_DROP;
                            if (is_mem) begin
                                ur_p_q  <= is_wr;
                                ur_np_q <= !is_wr;
                            end
                        end else if (is_mem && is_wr) begin
                            if (hdr_ok) begin
                                wr_addr_q  <= addr_w[BAR_ADDR_WIDTH-1:0];
                                wr_data_q  <= data_w;
                                wr_valid_q <= 1'b1;
                                state_q    <= S_WR_OUT;
                            end else begin
                                ur_p_q <= 1'b1;
                            end
                        end else if (is_mem) begin
                            // Reads always go out so a UR completion can be returned
                            rd_valid_q  <= 1'b1;
                            rd_addr_q   <= is_4dw ? '0 : addr_w[BAR_ADDR_WIDTH-1:0];
                            rd_req_id_q <= dw1[31:16];
                            rd_tag_q    <= dw1[15:8];
                            rd_ur_q     <= !hdr_ok;
                            ur_np_q     <= !hdr_ok;
                            state_q     <= S_RD_OUT;
                        end
                    end
                end
                S_WR_OUT: begin
                    if (wr_ready) begin
                        wr_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                S_RD_OUT: begin
                    if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                        rd_ur_q    <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (beat_acc && rx_st_eop)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef FEJKON_RX_DECODE_STATS_EN
    logic [31:0] stat_wr_q, stat_rd_q, stat_ur_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
            stat_ur_q <= '0;
        end else begin
            if (wr_valid_q && wr_ready) stat_wr_q <= stat_wr_q + 32'd1;
            if (rd_hs)                  stat_rd_q <= stat_rd_q + 32'd1;
            if (ur_p_q || ur_np_q)      stat_ur_q <= stat_ur_q + 32'd1;
        end
    end

    assign stat_wr = stat_wr_q;
    assign stat_rd = stat_rd_q;
    assign stat_ur = stat_ur_q;
`endif

    assign wr_valid      = wr_valid_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign rd_valid      = rd_valid_q;
    assign rd_addr       = rd_addr_q;
    assign rd_req_id     = rd_req_id_q;
    assign rd_tag        = rd_tag_q;
    assign rd_ur         = rd_ur_q;
    assign cpl_err_ur_p  = ur_p_q;
    assign cpl_err_ur_np = ur_np_q;
    assign pending       = pending_q;

    wire unused_bits = &{1'b0, rx_st_data[255:160], dw0[23:10], dw2[1:0], rx_st_bar[7:1]};

endmodule

// File: tb/tb_fejkon_pcie_rx_decode.sv
// Directed bench for fejkon_pcie_rx_decode: vector table plus stall/reset/drop sequences.
module tb_fejkon_pcie_rx_decode;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] rx_st_data;
    logic         rx_st_valid, rx_st_sop, rx_st_eop, rx_st_ready;
    logic [7:0]   rx_st_bar;
    logic         wr_valid, wr_ready, rd_valid, rd_ready, rd_ur;
    logic [11:0]  wr_addr, rd_addr;
    logic [31:0]  wr_data;
    logic [15:0]  rd_req_id;
    logic [7:0]   rd_tag;
    logic         cpl_done, cpl_err_ur_p, cpl_err_ur_np;
    logic [5:0]   pending;
`ifdef FEJKON_RX_DECODE_STATS_EN
    logic [31:0]  stat_wr, stat_rd, stat_ur;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fejkon_pcie_rx_decode #(.BAR_ADDR_WIDTH(12), .MAX_PENDING(32)) dut (
        .clk(clk), .reset(reset),
        .rx_st_data(rx_st_data), .rx_st_valid(rx_st_valid), .rx_st_sop(rx_st_sop),
        .rx_st_eop(rx_st_eop), .rx_st_bar(rx_st_bar), .rx_st_ready(rx_st_ready),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_req_id(rd_req_id),
        .rd_tag(rd_tag), .rd_ur(rd_ur), .cpl_done(cpl_done),
        .cpl_err_ur_p(cpl_err_ur_p), .cpl_err_ur_np(cpl_err_ur_np),
`ifdef FEJKON_RX_DECODE_STATS_EN
        .stat_wr(stat_wr), .stat_rd(stat_rd), .stat_ur(stat_ur),
`endif
        .pending(pending)
    );

    typedef struct {
        logic [31:0] dw0, dw1, dw2, dw3, dw4;
        logic [7:0]  bar;
        logic        e_wr, e_rd, e_rur, e_urp, e_urnp;
        logic [11:0] e_addr;
        logic [31:0] e_data;
        logic [7:0]  e_tag;
        logic [15:0] e_rid;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drives one beat for one cycle; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] d0, d1, d2, d3, d4,
                        input logic sop, eop, input logic [7:0] bar);
        @(posedge clk); #1;
        chk("ready_before_beat", 32'(rx_st_ready), 32'd1);
        rx_st_data  = {96'd0, d4, d3, d2, d1, d0};
        rx_st_sop   = sop;
        rx_st_eop   = eop;
        rx_st_bar   = bar;
        rx_st_valid = 1'b1;
        @(posedge clk); #1;
        rx_st_valid = 1'b0;
        rx_st_sop   = 1'b0;
        rx_st_eop   = 1'b0;
    endtask

    task automatic pulse_cpl();
        cpl_done = 1'b1;
        @(posedge clk); #1;
        cpl_done = 1'b0;
    endtask

    initial begin
        //         dw0           dw1           dw2           dw3           dw4           bar    wr rd rur urp urnp addr     data           tag    rid
        vecs[0]  = '{32'h4000_0001, 32'h0100_000F, 32'h0000_0010, 32'hDEAD_0000, 32'h0000_1337, 8'h01, 1, 0, 0, 0, 0, 12'h010, 32'h0000_1337, 8'h00, 16'h0100};
        vecs[1]  = '{32'h4000_0001, 32'h0100_000F, 32'h0000_0014, 32'hCAFE_BABE, 32'h5555_5555, 8'h01, 1, 0, 0, 0, 0, 12'h014, 32'hCAFE_BABE, 8'h00, 16'h0100};
        vecs[2]  = '{32'h4000_0002, 32'h0100_003C, 32'h0000_000E, 32'h0,         32'h0,         8'h01, 0, 0, 0, 1, 0, 12'h000, 32'h0,         8'h00, 16'h0000};
        vecs[3]  = '{32'h0000_0002, 32'h0100_053C, 32'h0000_000E, 32'h0,         32'h0,         8'h01, 0, 1, 1, 0, 1, 12'h00C, 32'h0,         8'h05, 16'h0100};
        vecs[4]  = '{32'h0000_0001, 32'hABCD_220F, 32'h0000_0040, 32'h0,         32'h0,         8'h01, 0, 1, 0, 0, 0, 12'h040, 32'h0,         8'h22, 16'hABCD};
        vecs[5]  = '{32'h4000_0001, 32'h0100_000F, 32'h0000_0010, 32'h0,         32'h1,         8'h02, 0, 0, 0, 1, 0, 12'h000, 32'h0,         8'h00, 16'h0000};
        vecs[6]  = '{32'h4000_0001, 32'h0100_000F, 32'h0000_1000, 32'h0,         32'h1,         8'h01, 0, 0, 0, 1, 0, 12'h000, 32'h0,         8'h00, 16'h0000};
        vecs[7]  = '{32'h2000_0001, 32'h0100_070F, 32'h0000_0000, 32'h0000_0040, 32'h0,         8'h01, 0, 1, 1, 0, 1, 12'h000, 32'h0,         8'h07, 16'h0100};
        vecs[8]  = '{32'h6000_0001, 32'h0100_000F, 32'h0000_0000, 32'h0000_0010, 32'h1,         8'h01, 0, 0, 0, 1, 0, 12'h000, 32'h0,         8'h00, 16'h0000};
        vecs[9]  = '{32'h4A00_0001, 32'h0100_000F, 32'h0000_0010, 32'h0,         32'h1,         8'h01, 0, 0, 0, 0, 0, 12'h000, 32'h0,         8'h00, 16'h0000};
        vecs[10] = '{32'h0000_0001, 32'h0100_09FF, 32'h0000_0020, 32'h0,         32'h0,         8'h01, 0, 1, 1, 0, 1, 12'h020, 32'h0,         8'h09, 16'h0100};
        vecs[11] = '{32'h0000_0001, 32'h0100_0A0F, 32'h0000_0FFC, 32'h0,         32'h0,         8'h01, 0, 1, 0, 0, 0, 12'hFFC, 32'h0,         8'h0A, 16'h0100};

        reset = 1'b1; rx_st_data = '0; rx_st_valid = 1'b0; rx_st_sop = 1'b0; rx_st_eop = 1'b0;
        rx_st_bar = 8'h00; wr_ready = 1'b1; rd_ready = 1'b1; cpl_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_ur", 32'({rd_ur, cpl_err_ur_p, cpl_err_ur_np}), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_regs", 32'({wr_addr, rd_addr}) | wr_data, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].dw0, vecs[i].dw1, vecs[i].dw2, vecs[i].dw3, vecs[i].dw4, 1'b1, 1'b1, vecs[i].bar);
            chk($sformatf("v%0d_wr_valid", i), 32'(wr_valid), 32'(vecs[i].e_wr));
            chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_ur_p", i), 32'(cpl_err_ur_p), 32'(vecs[i].e_urp));
            chk($sformatf("v%0d_ur_np", i), 32'(cpl_err_ur_np), 32'(vecs[i].e_urnp));
            if (vecs[i].e_wr) begin
                chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].e_addr));
                chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].e_data);
            end
            if (vecs[i].e_rd) begin
                chk($sformatf("v%0d_rd_ur", i), 32'(rd_ur), 32'(vecs[i].e_rur));
                chk($sformatf("v%0d_rd_addr", i), 32'(rd_addr), 32'(vecs[i].e_addr));
                chk($sformatf("v%0d_rd_tag", i), 32'(rd_tag), 32'(vecs[i].e_tag));
                chk($sformatf("v%0d_rd_req_id", i), 32'(rd_req_id), 32'(vecs[i].e_rid));
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_pulses_clear", i), 32'({cpl_err_ur_p, cpl_err_ur_np, wr_valid, rd_valid}), 32'd0);
            chk($sformatf("v%0d_pending", i), 32'(pending), 32'(vecs[i].e_rd));
            if (vecs[i].e_rd) pulse_cpl();
        end

        // Fill the completion budget
        for (int t = 0; t < 32; t++)
            send(32'h0000_0001, {16'h0200, 8'(t), 8'h0F}, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 1'b1, 8'h01);
        chk("fill_last_tag", 32'(rd_tag), 32'd31);
        @(posedge clk); #1;
        chk("fill_pending", 32'(pending), 32'd32);
        chk("fill_ready_low", 32'(rx_st_ready), 32'd0);
        pulse_cpl();
        chk("drain1_pending", 32'(pending), 32'd31);
        chk("drain1_ready", 32'(rx_st_ready), 32'd1);
        cpl_done = 1'b1;
        repeat (31) @(posedge clk);
        #1;
        chk("drain_pending", 32'(pending), 32'd0);
        @(posedge clk); #1;
        cpl_done = 1'b0;
        chk("nowrap_pending", 32'(pending), 32'd0);

        // Read held by a stalled consumer, completions arriving meanwhile
        send(32'h0000_0001, 32'h0100_010F, 32'h0000_0004, 32'h0, 32'h0, 1'b1, 1'b1, 8'h01);
        send(32'h0000_0001, 32'h0100_020F, 32'h0000_0008, 32'h0, 32'h0, 1'b1, 1'b1, 8'h01);
        @(posedge clk); #1;
        chk("stall_pre_pending", 32'(pending), 32'd2);
        rd_ready = 1'b0;
        send(32'h0000_0001, 32'h1234_770F, 32'h0000_0080, 32'h0, 32'h0, 1'b1, 1'b1, 8'h01);
        chk("stall_rd_valid", 32'(rd_valid), 32'd1);
        for (int c = 0; c < 3; c++) begin
            cpl_done = (c == 1);
            @(posedge clk); #1;
            chk($sformatf("stall%0d_payload", c), {rd_req_id, rd_tag, 7'd0, rd_valid}, {16'h1234, 8'h77, 8'h01});
            chk($sformatf("stall%0d_addr", c), 32'(rd_addr), 32'h080);
            chk($sformatf("stall%0d_ready_low", c), 32'(rx_st_ready), 32'd0);
        end
        cpl_done = 1'b0;
        chk("stall_pending", 32'(pending), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_rd_valid_mid", 32'(rd_valid), 32'd0);
        chk("rst_pending_mid", 32'(pending), 32'd0);
        chk("rst_rd_regs_mid", {rd_req_id, rd_tag, 4'd0, rd_addr[11:8]}, 32'd0);
        chk("rst_rd_addr_mid", 32'(rd_addr), 32'd0);
        reset = 1'b0;
        rd_ready = 1'b1;

        // Multi-beat write is UR; its trailing beat must not decode
        send(32'h4000_0001, 32'h0100_000F, 32'h0000_0010, 32'h0, 32'h1, 1'b1, 1'b0, 8'h01);
        chk("mb_ur_p", 32'(cpl_err_ur_p), 32'd1);
        chk("mb_ur_np", 32'(cpl_err_ur_np), 32'd0);
        chk("mb_wr_valid", 32'(wr_valid), 32'd0);
        chk("mb_drop_ready", 32'(rx_st_ready), 32'd1);
        send(32'h0000_0001, 32'h0100_550F, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 1'b1, 8'h01);
        chk("mb_tail_rd_valid", 32'(rd_valid), 32'd0);
        chk("mb_tail_ur", 32'({cpl_err_ur_p, cpl_err_ur_np}), 32'd0);
        send(32'h0000_0001, 32'h0100_3C0F, 32'h0000_0030, 32'h0, 32'h0, 1'b1, 1'b1, 8'h01);
        chk("mb_next_rd_valid", 32'(rd_valid), 32'd1);
        chk("mb_next_rd_tag", 32'(rd_tag), 32'h3C);
        chk("mb_next_rd_ur", 32'(rd_ur), 32'd0);
        chk("mb_next_rd_addr", 32'(rd_addr), 32'h030);
        @(posedge clk); #1;
        pulse_cpl();

        // Stray non-sop beat in IDLE
        send(32'h0000_0001, 32'h0100_660F, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 1'b1, 8'h01);
        chk("stray_rd_valid", 32'(rd_valid), 32'd0);
        chk("stray_pending", 32'(pending), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
